// File: rtl/arf086b128e1r1w0cbbehsaa4acw_pkg.sv
// Shared types and defaults for the 1R1W array request scheduler.
// Default geometry: 128 entries of 86 bits.
package arf086b128e1r1w0cbbehsaa4acw_pkg;

  localparam int WIDTH_DEF = 86;
  localparam int DEPTH_DEF = 128;
  localparam int ADR_W_DEF = 7;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADR_W_DEF-1:0] adr;
    logic [WIDTH_DEF-1:0] data;
  } req_t;

endpackage

// File: rtl/arf086b128e1r1w0cbbehsaa4acw_rr_arb2.sv
// Two-way round-robin arbiter with a grant enable.
// pick is the tentative winner; gnt is pick qualified by en.
module arf086b128e1r1w0cbbehsaa4acw_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] pick,
  output logic [1:0] gnt
);

  logic last;

  // Favour the requester that did not win most recently
  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last ? 2'b01 : 2'b10;
    end
  end

  assign gnt = en ? pick : 2'b00;

  // Remember the last winner; only a real grant moves it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (|gnt) begin
      last <= gnt[1];
    end
  end

endmodule

// File: rtl/arf086b128e1r1w0cbbehsaa4acw_rw_sched.sv
// Write/read request scheduler for a 1R1W array with zero-init.
// Option macro: ARF086B128E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN
module arf086b128e1r1w0cbbehsaa4acw_rw_sched
  import arf086b128e1r1w0cbbehsaa4acw_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADR_W = ADR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            wreq_valid,
  input  logic [1:0][ADR_W-1:0] wreq_adr,
  input  logic [1:0][WIDTH-1:0] wreq_data,
  output logic [1:0]            wreq_ready,
  input  logic [1:0]            rreq_valid,
  input  logic [1:0][ADR_W-1:0] rreq_adr,
  output logic [1:0]            rreq_ready,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  arr_wr_en,
  output logic [ADR_W-1:0]      arr_wr_adr,
  output logic [WIDTH-1:0]      arr_wr_data,
  output logic                  arr_rd_en,
  output logic [ADR_W-1:0]      arr_rd_adr,
  input  logic [WIDTH-1:0]      arr_rd_data,
  output logic                  wr_clk_en,
  output logic                  rd_clk_en,
  output logic                  init_done
);

  state_t           state;
  state_t           state_nxt;
  logic [ADR_W-1:0] cnt;
  logic [1:0]       wpick;
  logic [1:0]       wgnt;
  logic [1:0]       rpick;
  logic [1:0]       rgnt;
  logic             run;
  logic             col;
  logic             rd_allow;
  req_t             wsel;
  logic [ADR_W-1:0] radr;

  assign run = (state == ST_RUN) && !rst;

  assign wsel.adr  = wreq_adr[wpick[1]];
  assign wsel.data = wreq_data[wpick[1]];
  assign radr      = rreq_adr[rpick[1]];

  assign col = (|wpick) && (|rpick)
            && (wsel.adr == radr);

`ifdef ARF086B128E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN
  assign rd_allow = run;
`else
  assign rd_allow = run && !col;
`endif

  arf086b128e1r1w0cbbehsaa4acw_rr_arb2 u_warb (
    .clk  (clk),
    .rst  (rst),
    .req  (wreq_valid),
    .en   (run),
    .pick (wpick),
    .gnt  (wgnt)
  );

  arf086b128e1r1w0cbbehsaa4acw_rr_arb2 u_rarb (
    .clk  (clk),
    .rst  (rst),
    .req  (rreq_valid),
    .en   (rd_allow),
    .pick (rpick),
    .gnt  (rgnt)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Leave INIT once the last entry has been cleared
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_INIT: begin
        if (cnt == ADR_W'(DEPTH - 1)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: state_nxt = ST_RUN;
    endcase
  end

  // Init address counter, one entry per INIT cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt + ADR_W'(1);
    end
  end

  // Array port drive: zero-fill in INIT, granted traffic in RUN
  always_comb begin
    arr_wr_en   = 1'b0;
    arr_wr_adr  = '0;
    arr_wr_data = '0;
    arr_rd_en   = 1'b0;
    arr_rd_adr  = '0;
    unique case (state)
      ST_INIT: begin
        arr_wr_en  = !rst;
        arr_wr_adr = cnt;
      end
      ST_RUN: begin
        arr_wr_en   = |wgnt;
        arr_wr_adr  = wsel.adr;
        arr_wr_data = wsel.data;
        arr_rd_en   = |rgnt;
        arr_rd_adr  = radr;
      end
    endcase
  end

  assign wreq_ready = wgnt;
  assign rreq_ready = rgnt;
  assign wr_clk_en  = arr_wr_en;
  assign rd_clk_en  = arr_rd_en;
  assign init_done  = (state == ST_RUN);

`ifdef ARF086B128E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN
  logic             byp_hit;
  logic [WIDTH-1:0] byp_data;

  // Capture write data that a same-address read must observe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit <= (|rgnt) && col;
      if ((|rgnt) && col) begin
        byp_data <= wsel.data;
      end
    end
  end

  assign rsp_data = !rsp_valid ? '0
                  : byp_hit ? byp_data
                  : arr_rd_data;
`else
  assign rsp_data = rsp_valid ? arr_rd_data : '0;
`endif

  // Response tag tracks the read granted one cycle earlier
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      rsp_valid <= |rgnt;
      if (|rgnt) begin
        rsp_id <= rgnt[1];
      end
    end
  end

endmodule

// File: tb/tb_arf086b128e1r1w0cbbehsaa4acw_rw_sched.sv
// Bench for the 1R1W request scheduler: table vectors,
// directed corner sequences and a randomized reference model.
module tb_arf086b128e1r1w0cbbehsaa4acw_rw_sched;

  localparam int W  = 86;
  localparam int D  = 128;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]         wreq_valid;
  logic [1:0][AW-1:0] wreq_adr;
  logic [1:0][W-1:0]  wreq_data;
  logic [1:0]         wreq_ready;
  logic [1:0]         rreq_valid;
  logic [1:0][AW-1:0] rreq_adr;
  logic [1:0]         rreq_ready;
  logic               rsp_valid;
  logic               rsp_id;
  logic [W-1:0]       rsp_data;
  logic               arr_wr_en;
  logic [AW-1:0]      arr_wr_adr;
  logic [W-1:0]       arr_wr_data;
  logic               arr_rd_en;
  logic [AW-1:0]      arr_rd_adr;
  logic [W-1:0]       arr_rd_data;
  logic               wr_clk_en;
  logic               rd_clk_en;
  logic               init_done;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  arf086b128e1r1w0cbbehsaa4acw_rw_sched dut (
    .clk         (clk),
    .rst         (rst),
    .wreq_valid  (wreq_valid),
    .wreq_adr    (wreq_adr),
    .wreq_data   (wreq_data),
    .wreq_ready  (wreq_ready),
    .rreq_valid  (rreq_valid),
    .rreq_adr    (rreq_adr),
    .rreq_ready  (rreq_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .arr_wr_en   (arr_wr_en),
    .arr_wr_adr  (arr_wr_adr),
    .arr_wr_data (arr_wr_data),
    .arr_rd_en   (arr_rd_en),
    .arr_rd_adr  (arr_rd_adr),
    .arr_rd_data (arr_rd_data),
    .wr_clk_en   (wr_clk_en),
    .rd_clk_en   (rd_clk_en),
    .init_done   (init_done)
  );

  // Array model: synchronous write, registered read-before-write
  logic [W-1:0] amem [D];
  always @(posedge clk) begin
    if (arr_wr_en) amem[arr_wr_adr] <= arr_wr_data;
    if (arr_rd_en) arr_rd_data <= amem[arr_rd_adr];
  end

  // Reference model state
  logic [W-1:0] mm [D];
  logic         m_wlast;
  logic         m_rlast;
  logic         m_pend;
  logic         m_id;
  logic [W-1:0] m_data;

  typedef struct {
    logic [1:0]   wr;
    logic [1:0]   rr;
    logic         rv;
    logic         rid;
    logic [W-1:0] rd;
  } obs_t;

  typedef struct {
    logic [1:0] wv;
    logic [1:0] rv;
    logic [1:0] ew;
    logic [1:0] er;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int winner(input logic [1:0] v,
                                input logic last);
    if (v[0] && v[1]) return last ? 0 : 1;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) mm[i] = '0;
    m_wlast = 1'b1;
    m_rlast = 1'b1;
    m_pend  = 1'b0;
    m_id    = 1'b0;
    m_data  = '0;
  endtask

  task automatic drive(input logic [1:0] wv,
                       input logic [1:0] rv,
                       input int wa0, input int wa1,
                       input logic [W-1:0] wd0,
                       input logic [W-1:0] wd1,
                       input int ra0, input int ra1);
    wreq_valid   = wv;
    rreq_valid   = rv;
    wreq_adr[0]  = AW'(wa0);
    wreq_adr[1]  = AW'(wa1);
    wreq_data[0] = wd0;
    wreq_data[1] = wd1;
    rreq_adr[0]  = AW'(ra0);
    rreq_adr[1]  = AW'(ra1);
  endtask

  task automatic idle();
    drive(2'b00, 2'b00, 0, 0, '0, '0, 0, 0);
  endtask

  // One RUN cycle: check outputs against the model, then advance it
  task automatic run_cycle(output obs_t o);
    int wi;
    int ri;
    logic col;
    logic [1:0] ew;
    logic [1:0] er;
    logic np;
    logic nid;
    logic [W-1:0] nd;
    @(negedge clk);
    o.wr = wreq_ready;
    o.rr = rreq_ready;
    o.rv = rsp_valid;
    o.rid = rsp_id;
    o.rd = rsp_data;
    chk("rsp_valid", rsp_valid, m_pend);
    if (m_pend) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_data", rsp_data, m_data);
    end
    wi = winner(wreq_valid, m_wlast);
    ri = winner(rreq_valid, m_rlast);
    col = (wi >= 0) && (ri >= 0)
       && (wreq_adr[wi] == rreq_adr[ri]);
`ifndef ARF086B128E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN
    if (col) ri = -1;
`endif
    ew = (wi < 0) ? 2'b00 : 2'(1 << wi);
    er = (ri < 0) ? 2'b00 : 2'(1 << ri);
    chk("wreq_ready", wreq_ready, ew);
    chk("rreq_ready", rreq_ready, er);
    chk("w_onehot", $onehot0(wreq_ready), 1);
    chk("r_onehot", $onehot0(rreq_ready), 1);
    chk("arr_wr_en", arr_wr_en, wi >= 0);
    chk("wr_clk_en", wr_clk_en, wi >= 0);
    chk("arr_rd_en", arr_rd_en, ri >= 0);
    chk("rd_clk_en", rd_clk_en, ri >= 0);
    if (wi >= 0) begin
      chk("arr_wr_adr", arr_wr_adr, wreq_adr[wi]);
      chk("arr_wr_data", arr_wr_data, wreq_data[wi]);
    end
    if (ri >= 0) begin
      chk("arr_rd_adr", arr_rd_adr, rreq_adr[ri]);
    end
    np  = (ri >= 0);
    nid = (ri == 1);
    nd  = '0;
    if (ri >= 0) begin
      nd = col ? wreq_data[wi] : mm[rreq_adr[ri]];
    end
    @(posedge clk);
    if (wi >= 0) begin
      mm[wreq_adr[wi]] = wreq_data[wi];
      m_wlast = (wi == 1);
    end
    if (ri >= 0) m_rlast = (ri == 1);
    m_pend = np;
    m_id   = nid;
    m_data = nd;
    #1;
  endtask

  // Zero-fill phase: one write per cycle, no grants while busy
  task automatic init_check();
    wreq_valid = 2'b11;
    rreq_valid = 2'b11;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk("init_wr_en", arr_wr_en, 1);
      chk("init_wr_adr", arr_wr_adr, i);
      chk("init_wr_data", arr_wr_data, 0);
      chk("init_ready", {wreq_ready, rreq_ready}, 0);
      chk("init_rd_en", arr_rd_en, 0);
      chk("init_done_lo", init_done, 0);
      chk("init_rsp", rsp_valid, 0);
    end
    idle();
    @(negedge clk);
    chk("init_done_hi", init_done, 1);
    chk("run_idle_wr", arr_wr_en, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) begin
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_en", {arr_wr_en, arr_rd_en,
                     wr_clk_en, rd_clk_en}, 0);
      chk("rst_ready", {wreq_ready, rreq_ready}, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    init_check();
  endtask

  initial begin
    obs_t o;
    vec_t tbl [10];
    logic [W-1:0] d0;
    logic [W-1:0] d1;

    tbl[0] = '{2'b11, 2'b00, 2'b01, 2'b00};
    tbl[1] = '{2'b11, 2'b00, 2'b10, 2'b00};
    tbl[2] = '{2'b11, 2'b00, 2'b01, 2'b00};
    tbl[3] = '{2'b11, 2'b00, 2'b10, 2'b00};
    tbl[4] = '{2'b00, 2'b00, 2'b00, 2'b00};
    tbl[5] = '{2'b11, 2'b11, 2'b01, 2'b01};
    tbl[6] = '{2'b10, 2'b10, 2'b10, 2'b10};
    tbl[7] = '{2'b00, 2'b11, 2'b00, 2'b01};
    tbl[8] = '{2'b01, 2'b01, 2'b01, 2'b01};
    tbl[9] = '{2'b11, 2'b11, 2'b10, 2'b10};

    idle();
    #1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].wv, tbl[i].rv, 20, 21,
            W'(100 + i), W'(200 + i), 30, 31);
      run_cycle(o);
      chk($sformatf("tbl%0d_wgnt", i), o.wr, tbl[i].ew);
      chk($sformatf("tbl%0d_rgnt", i), o.rr, tbl[i].er);
    end
    idle();
    run_cycle(o);

    drive(2'b01, 2'b00, 5, 0, W'('h15), '0, 0, 0);
    run_cycle(o);
    chk("wr5_gnt", o.wr, 2'b01);
    idle();
    run_cycle(o);
    drive(2'b00, 2'b10, 0, 0, '0, '0, 0, 5);
    run_cycle(o);
    chk("rd5_gnt", o.rr, 2'b10);
    idle();
    run_cycle(o);
    chk("rd5_valid", o.rv, 1);
    chk("rd5_id", o.rid, 1);
    chk("rd5_data", o.rd, W'('h15));

    drive(2'b01, 2'b01, 9, 0, W'('h2A), '0, 9, 0);
    run_cycle(o);
    chk("col_wgnt", o.wr, 2'b01);
`ifdef ARF086B128E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN
    chk("col_rgnt", o.rr, 2'b01);
    idle();
    run_cycle(o);
`else
    chk("col_rgnt", o.rr, 2'b00);
    drive(2'b00, 2'b01, 0, 0, '0, '0, 9, 0);
    run_cycle(o);
    chk("col_rgnt_next", o.rr, 2'b01);
    idle();
    run_cycle(o);
`endif
    chk("col_valid", o.rv, 1);
    chk("col_data", o.rd, W'('h2A));

    drive(2'b00, 2'b01, 0, 0, '0, '0, 9, 0);
    run_cycle(o);
    chk("pre_rst_rgnt", o.rr, 2'b01);
    do_reset();

    for (int c = 0; c < 1000; c++) begin
      d0 = W'({$urandom, $urandom, $urandom});
      d1 = W'({$urandom, $urandom, $urandom});
      drive(2'($urandom), 2'($urandom),
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), d0, d1,
            int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)));
      run_cycle(o);
    end
    idle();
    run_cycle(o);
    run_cycle(o);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/arf086b128e1r1w0cbbehsaa4acw_rw_sched.md
ARF086B128E1R1W0CBBEHSAA4ACW_RW_SCHED -- requirements
Module: arf086b128e1r1w0cbbehsaa4acw_rw_sched

Interface
REQ-001 SHALL have parameters, one per line:
  WIDTH, 86, data bits per entry.
  DEPTH, 128, entries.
  ADR_W, 7, address bits (clog2 DEPTH).
REQ-002 SHALL have ports, one per line:
  clk  in  1  the single clock; every flop is on its rising edge.
  rst  in  1  asynchronous, active-high reset.
  wreq_valid  in  2  write request per requester (bit0=W0, bit1=W1).
  wreq_adr  in  2xADR_W  write address per requester.
  wreq_data  in  2xWIDTH  write data per requester.
  wreq_ready  out  2  write accepted this cycle.
  rreq_valid  in  2  read request per requester (R0, R1).
  rreq_adr  in  2xADR_W  read address per requester.
  rreq_ready  out  2  read accepted this cycle.
  rsp_valid  out  1  read data valid.
  rsp_id  out  1  requester the response belongs to.
  rsp_data  out  WIDTH  read data.
  arr_wr_en, arr_wr_adr, arr_wr_data  out  1/ADR_W/WIDTH  array write port.
  arr_rd_en, arr_rd_adr  out  1/ADR_W  array read port.
  arr_rd_data  in  WIDTH  array read data, valid one cycle after arr_rd_en.
  wr_clk_en, rd_clk_en  out  1  enables for the array write/read clock gates.
  init_done  out  1  array initialisation finished.

Function
REQ-003 SHALL run FSM INIT -> RUN; INIT entered on reset, RUN entered after the last init write; RUN is left only by reset.
REQ-004 In INIT SHALL write zero to addresses 0..DEPTH-1, one per cycle, ascending; wreq_ready=rreq_ready=0; arr_rd_en=0.
REQ-005 Init counter SHALL reach DEPTH-1, issue that write, then move to RUN the next cycle; init_done=1 from the first RUN cycle.
REQ-006 In RUN, write port SHALL grant at most one of W0/W1 per cycle; grant = wreq_ready bit; accepted write drives arr_wr_en/adr/data combinationally in the same cycle.
REQ-007 Read port SHALL grant at most one of R0/R1 per cycle; grant drives arr_rd_en/adr in the same cycle.
REQ-008 Each port SHALL use a round-robin pointer: when both requesters are valid, the one not granted last wins; when one is valid it wins; the pointer updates only on a grant.
REQ-009 rsp_valid SHALL assert exactly one cycle after a read grant, with rsp_id = granted requester and rsp_data = arr_rd_data (or bypass data, REQ-014).
REQ-010 wr_clk_en SHALL equal arr_wr_en and rd_clk_en SHALL equal arr_rd_en in the same cycle; both are 0 when idle.
REQ-011 Write/read address collision (same-cycle granted write and read to equal address) SHALL be resolved per REQ-014.
REQ-012 Back-to-back grants SHALL be sustained: one write and one read per cycle, full throughput, no bubbles without collision.

Reset
REQ-013 On rst: state=INIT, init counter=0, both round-robin pointers favour requester 0, rsp_valid=0, rsp_id=0, rsp_data=0, init_done=0, all ready/enable outputs 0; reset mid-operation aborts any in-flight response (no rsp_valid after reset release) and restarts initialisation.

Configuration
REQ-014 Macro ARF086B128E1R1W0CBBEHSAA4ACW_WR_BYPASS_EN: defined -> colliding read is granted and rsp_data next cycle = the colliding write data (registered); undefined -> colliding read is not granted that cycle (rreq_ready=0, round-robin pointer unchanged) and is granted the next cycle if still valid.

Structure
REQ-015 Shared package SHALL hold WIDTH/DEPTH/ADR_W defaults, the FSM state enum, and the request struct (adr, data).
REQ-016 One sub-module SHALL be natural: arf086b128e1r1w0cbbehsaa4acw_rr_arb2 (2-way round-robin arbiter), instantiated twice (write, read).

Verification
REQ-017 Reset release -> 128 consecutive arr_wr_en cycles, adr 0..127, data 0; init_done rises at cycle 129; no ready before.
REQ-018 After init, W0 and W1 both valid for 4 cycles -> grants W0,W1,W0,W1; pointer held during idle gaps.
REQ-019 W0 writes 0x15 to adr 5; two cycles later R1 reads adr 5 -> rsp_valid one cycle after grant, rsp_id=1, rsp_data=0x15.
REQ-020 Same cycle W0 writes 0x2A to adr 9 and R0 reads adr 9 -> with macro: granted, rsp_data=0x2A next cycle; without: rreq_ready=0, grant next cycle, rsp_data=0x2A.
REQ-021 Assert rst the cycle after a read grant -> no rsp_valid; init restarts at adr 0; init_done=0 until 128 writes complete.
REQ-022 Continuous traffic on all four requesters for 1000 cycles, random addresses -> scoreboard matches every response; never two grants per port per cycle.
